// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory-mapped peripheral block: register word
// offsets (Address[7:2]), TCON bit positions and the default window base.
package mem_bus_pkg;

    // Default base of the 256-byte peripheral window.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Register word offsets, i.e. byte offset >> 2.
    localparam logic [5:0] OFF_TH      = 6'h00;  // byte 0x00
    localparam logic [5:0] OFF_TL      = 6'h01;  // byte 0x04
    localparam logic [5:0] OFF_TCON    = 6'h02;  // byte 0x08
    localparam logic [5:0] OFF_LED     = 6'h03;  // byte 0x0C
    localparam logic [5:0] OFF_DIGI    = 6'h04;  // byte 0x10
    localparam logic [5:0] OFF_SYSTICK = 6'h05;  // byte 0x14

    // TCON bit indices.
    localparam int TCON_EN = 0;  // timer enable
    localparam int TCON_IE = 1;  // interrupt enable
    localparam int TCON_IS = 2;  // interrupt status (sticky)

    // Per-register write strobes produced by the address decoder.
    typedef struct packed {
        logic th;
        logic tl;
        logic tcon;
        logic led;
        logic digi;
    } reg_we_t;

endpackage

// File: rtl/mem_bus_peripheral_bus_timer.sv
// Reloadable up-counting timer: TH (reload), TL (count), TCON (control and
// sticky status) and the level interrupt.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module bus_timer
    import mem_bus_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic tick;
    logic overflow;
    logic set_is;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc;

    // Prescaler: free-runs while enabled, restarts whenever the count is
    // rewritten or the timer is stopped so the first period is always full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (!tcon[TCON_EN] || tl_we) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESCALE_W'(1);
        end
    end

    assign tick = tcon[TCON_EN] && (presc == '1);
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE_W > 0);
    assign tick            = tcon[TCON_EN];
`endif

    assign overflow = tick && (tl == 32'hFFFF_FFFF);
    assign set_is   = overflow && tcon[TCON_IE];

    // Reload register: plain CPU-written storage; the reload reads the value
    // held before this edge, so a same-cycle write lands after the reload.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (th_we) begin
            th <= wdata;
        end
    end

    // Count register: a CPU write beats the tick in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (tl_we) begin
            tl <= wdata;
        end else if (overflow) begin
            tl <= th;
        end else if (tick) begin
            tl <= tl + 32'd1;
        end
    end

    // Control/status: an overflow that sets the status wins over a software
    // clear in the same cycle so an interrupt is never dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else if (tcon_we) begin
            tcon[TCON_EN] <= wdata[TCON_EN];
            tcon[TCON_IE] <= wdata[TCON_IE];
            tcon[TCON_IS] <= wdata[TCON_IS] | set_is;
        end else if (set_is) begin
            tcon[TCON_IS] <= 1'b1;
        end
    end

    assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/mem_bus_peripheral.sv
// Memory-mapped peripheral responder on the CPU data bus: address decode,
// LED and 7-segment registers, free-running SYSTICK and the read mux.
// The timer lives in bus_timer; TIMER_PRESCALE_EN adds its prescaler.
module mem_bus_peripheral
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          LED_W      = 12,
    parameter int          DIGI_W     = 12,
    parameter int          PRESCALE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    output logic [31:0]       Read_data,
    output logic [LED_W-1:0]  leds,
    output logic [DIGI_W-1:0] digi,
    output logic              irq
);

    logic        hit;
    logic [5:0]  offset;
    reg_we_t     we;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic [1:0]  unused_addr_lsb;

    assign hit             = (Address[31:8] == BASE_ADDR[31:8]);
    assign offset          = Address[7:2];
    assign unused_addr_lsb = Address[1:0];

    // Write decode: one strobe per writable register; SYSTICK and holes ignore stores.
    // NOTE: defaulting every output first keeps this block free of latches.
    always_comb begin
        we = '0;
        if (MemWrite && hit) begin
            unique case (offset)
                OFF_TH:   we.th   = 1'b1;
                OFF_TL:   we.tl   = 1'b1;
                OFF_TCON: we.tcon = 1'b1;
                OFF_LED:  we.led  = 1'b1;
                OFF_DIGI: we.digi = 1'b1;
                default:  ;
            endcase
        end
    end

    bus_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .th_we   (we.th),
        .tl_we   (we.tl),
        .tcon_we (we.tcon),
        .wdata   (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // LED register: low LED_W bits of the store data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= '0;
        end else if (we.led) begin
            leds <= Write_data[LED_W-1:0];
        end
    end

    // 7-segment register: low DIGI_W bits of the store data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digi <= '0;
        end else if (we.digi) begin
            digi <= Write_data[DIGI_W-1:0];
        end
    end

    // SYSTICK: free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // Read mux: zero-latency, zero-extended, zero when not addressed.
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit) begin
            unique case (offset)
                OFF_TH:      Read_data = th;
                OFF_TL:      Read_data = tl;
                OFF_TCON:    Read_data = {29'h0, tcon};
                OFF_LED:     Read_data = 32'(leds);
                OFF_DIGI:    Read_data = 32'(digi);
                OFF_SYSTICK: Read_data = systick;
                default:     Read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_peripheral.sv
// Directed self-checking bench for mem_bus_peripheral with a scoreboard queue.
// Honors TIMER_PRESCALE_EN (DUT built with PRESCALE_W=2).
module tb_mem_bus_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;
    localparam logic [31:0] A_HOLE = 32'h4000_0018;
    localparam logic [31:0] A_FAR  = 32'h5000_0004;
`ifdef TIMER_PRESCALE_EN
    localparam int TICK_DIV = 4;
`else
    localparam int TICK_DIV = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [11:0] leds;
    logic [11:0] digi;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] tick_model;
    logic [31:0] tick_snap;

    mem_bus_peripheral #(
        .PRESCALE_W (2)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .MemRead    (mem_read),
        .MemWrite   (mem_write),
        .Address    (address),
        .Write_data (write_data),
        .Read_data  (read_data),
        .leds       (leds),
        .digi       (digi),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter for SYSTICK.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_model <= '0;
        else        tick_model <= tick_model + 32'd1;
    end

    task automatic push_exp(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] observed);
        exp_t e;
        e = sb.pop_front();
        tests++;
        assert (observed === e.value)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", e.tag, observed, e.value);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        push_exp(tag, expected);
        compare(observed);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge; the store lands on the following posedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mem_write  = 1'b1;
        address    = addr;
        write_data = data;
        @(negedge clk);
        mem_write  = 1'b0;
    endtask

    // Combinational load sampled mid-cycle; consumes no clock edge.
    task automatic bus_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] expected);
        push_exp(tag, expected);
        mem_read = 1'b1;
        address  = addr;
        #1;
        compare(read_data);
        mem_read = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        #1;
        check_out("por_leds", 32'(leds), 32'h0);
        check_out("por_irq", 32'(irq), 32'h0);
        check_out("por_rdata", read_data, 32'h0);
        step(2);
        rst_n = 1'b1;

        // LED / DIGI / holes / SYSTICK
        bus_write(A_LED, 32'hFFFF_F123);
        check_out("led_port", 32'(leds), 32'h0000_0123);
        bus_read("led_rd", A_LED, 32'h0000_0123);
        bus_read("hole_rd", A_HOLE, 32'h0);
        bus_write(A_DIGI, 32'h1234_5ABC);
        check_out("digi_port", 32'(digi), 32'h0000_0ABC);
        bus_read("digi_rd", A_DIGI, 32'h0000_0ABC);
        tick_snap = tick_model;
        bus_read("systick_a", A_SYS, tick_snap);
        bus_write(A_SYS, 32'h0);
        bus_read("systick_b", A_SYS, tick_snap + 32'd1);
        bus_write(A_TCON, 32'hFFFF_FFFA);
        bus_read("tcon_zext", A_TCON, 32'h0000_0002);
        check_out("tcon_ie_only_irq", 32'(irq), 32'h0);

`ifndef TIMER_PRESCALE_EN
        // Overflow and reload
        bus_write(A_TH, 32'hFFFF_FFFE);
        bus_write(A_TL, 32'hFFFF_FFFD);
        bus_write(A_TCON, 32'h3);
        bus_read("ovf_tl0", A_TL, 32'hFFFF_FFFD);
        step(1);
        bus_read("ovf_tl1", A_TL, 32'hFFFF_FFFE);
        step(1);
        bus_read("ovf_tl2", A_TL, 32'hFFFF_FFFF);
        check_out("ovf_irq_before", 32'(irq), 32'h0);
        step(1);
        bus_read("ovf_tl3", A_TL, 32'hFFFF_FFFE);
        check_out("ovf_irq_after", 32'(irq), 32'h1);
        bus_read("ovf_tcon", A_TCON, 32'h7);
        step(1);
        bus_read("ovf_tl4", A_TL, 32'hFFFF_FFFF);

        // Status clear racing an overflow, then a real clear
        bus_write(A_TCON, 32'h3);
        bus_read("race_tcon", A_TCON, 32'h7);
        check_out("race_irq", 32'(irq), 32'h1);
        bus_read("race_tl", A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        check_out("clear_irq", 32'(irq), 32'h0);
        bus_read("clear_tcon", A_TCON, 32'h3);

        // CPU write to TL beats the tick; out-of-window store ignored
        bus_write(A_TCON, 32'h1);
        bus_write(A_TL, 32'd10);
        bus_write(A_TL, 32'd100);
        bus_read("tlw_100", A_TL, 32'd100);
        step(1);
        bus_read("tlw_101", A_TL, 32'd101);
        bus_write(A_FAR, 32'h0);
        bus_read("far_tl", A_TL, 32'd102);
        bus_read("far_rd", A_FAR, 32'h0);
`endif

        // Tick rate (with or without prescaler)
        bus_write(A_TCON, 32'h0);
        bus_write(A_TL, 32'h0);
        bus_write(A_TCON, 32'h1);
        step(4);
        bus_read("rate_4", A_TL, 32'(4 / TICK_DIV));
        step(4);
        bus_read("rate_8", A_TL, 32'(8 / TICK_DIV));

        // Asynchronous reset mid-count with irq pending
        bus_write(A_TCON, 32'h0);
        bus_write(A_LED, 32'h0000_0ABC);
        bus_write(A_TH, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        step(2 * TICK_DIV);
        check_out("pre_rst_irq", 32'(irq), 32'h1);
        mem_read = 1'b1;
        address  = A_LED;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_leds", 32'(leds), 32'h0);
        check_out("rst_digi", 32'(digi), 32'h0);
        check_out("rst_irq", 32'(irq), 32'h0);
        check_out("rst_rdata", read_data, 32'h0);
        mem_read = 1'b0;
        step(1);
        rst_n = 1'b1;
        bus_read("post_systick", A_SYS, 32'h0);
        bus_read("post_th", A_TH, 32'h0);
        step(1);
        bus_read("post_tl", A_TL, 32'h0);
        bus_read("post_tcon", A_TCON, 32'h0);
        step(1);
        bus_read("post_led", A_LED, 32'h0);
        bus_read("post_digi", A_DIGI, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
